// File: rtl/panel_pkg.sv
// Shared front-panel definitions: digit type, display constants and Gray-to-binary conversion.
package panel_pkg;

    localparam logic [6:0]  SEG_BLANK  = 7'h7F;
    localparam int unsigned NUM_DIGITS = 4;

    typedef logic [3:0] digit_t;

    function automatic digit_t gray2bin(input digit_t g);
        digit_t b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Board-side I/O bundle of the front panel: switches and button in, display and LEDs out.
interface display_scan_ctrl_if;
    logic [3:0] gray_in;
    logic       btn_raw;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic [3:0] led;
    logic       cap_pulse;

    modport master (
        output gray_in, btn_raw,
        input  an_n, seg_n, led, cap_pulse
    );

    modport slave (
        input  gray_in, btn_raw,
        output an_n, seg_n, led, cap_pulse
    );
endinterface

// File: rtl/display_scan_ctrl_seg7_decode.sv
// Combinational hex to active-low 7-segment glyph decoder, bit order {g,f,e,d,c,b,a}.
module seg7_decode
    import panel_pkg::*;
(
    input  digit_t     i_hex,
    output logic [6:0] o_seg_n
);

    always_comb begin
        o_seg_n = SEG_BLANK;
        unique case (i_hex)
            4'h0: o_seg_n = 7'h40;
            4'h1: o_seg_n = 7'h79;
            4'h2: o_seg_n = 7'h24;
            4'h3: o_seg_n = 7'h30;
            4'h4: o_seg_n = 7'h19;
            4'h5: o_seg_n = 7'h12;
            4'h6: o_seg_n = 7'h02;
            4'h7: o_seg_n = 7'h78;
            4'h8: o_seg_n = 7'h00;
            4'h9: o_seg_n = 7'h10;
            4'hA: o_seg_n = 7'h08;
            4'hB: o_seg_n = 7'h03;
            4'hC: o_seg_n = 7'h46;
            4'hD: o_seg_n = 7'h21;
            4'hE: o_seg_n = 7'h06;
            4'hF: o_seg_n = 7'h0E;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Front-panel controller: debounced capture of Gray switches into a 4-deep history,
// multiplexed onto a 4-digit common-anode display through one shared decoder.
module display_scan_ctrl
    import panel_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter int unsigned DEB_CYCLES     = 500000
)(
    input  logic               clk,
    input  logic               rst_n,
    display_scan_ctrl_if.slave pif
);

    localparam int unsigned SLOT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic              r_btn_s1, r_btn_s2;
    digit_t            r_gray_s1, r_gray_s2;
    logic              r_deb;
    logic [DEB_W-1:0]  r_deb_cnt;
    digit_t            r_hist [NUM_DIGITS];
    logic [2:0]        r_n_valid;
    logic [1:0]        r_dig;
    logic [SLOT_W-1:0] r_slot_cnt;
    logic [3:0]        r_an_n;
    logic [6:0]        r_seg_n;
    digit_t            r_led;
    logic              r_cap_pulse;

    logic              w_deb_toggle;
    logic              w_capture;
    logic              w_slot_wrap;
    logic [6:0]        w_seg_n;
    digit_t            w_gray_bin;

    assign w_deb_toggle = (r_btn_s2 != r_deb) && (r_deb_cnt == DEB_W'(DEB_CYCLES - 1));
    assign w_capture    = w_deb_toggle && r_btn_s2;
    assign w_slot_wrap  = (r_slot_cnt == SLOT_W'(REFRESH_CYCLES - 1));
    assign w_gray_bin   = gray2bin(r_gray_s2);

    seg7_decode u_seg7 (
        .i_hex   (r_hist[r_dig]),
        .o_seg_n (w_seg_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s1    <= 1'b0;
            r_btn_s2    <= 1'b0;
            r_gray_s1   <= '0;
            r_gray_s2   <= '0;
            r_deb       <= 1'b0;
            r_deb_cnt   <= '0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) r_hist[i] <= '0;
            r_n_valid   <= '0;
            r_dig       <= '0;
            r_slot_cnt  <= '0;
            r_an_n      <= '1;
            r_seg_n     <= SEG_BLANK;
            r_led       <= '0;
            r_cap_pulse <= 1'b0;
        end else begin
            r_btn_s1  <= pif.btn_raw;
            r_btn_s2  <= r_btn_s1;
            r_gray_s1 <= pif.gray_in;
            r_gray_s2 <= r_gray_s1;

            if (r_btn_s2 == r_deb || w_deb_toggle) r_deb_cnt <= '0;
            else                                   r_deb_cnt <= r_deb_cnt + 1'b1;
            if (w_deb_toggle) r_deb <= ~r_deb;

            r_cap_pulse <= w_capture;
            if (w_capture) begin
                for (int unsigned i = 1; i < NUM_DIGITS; i++) r_hist[i] <= r_hist[i-1];
                r_hist[0] <= w_gray_bin;
                r_led     <= w_gray_bin;
                if (r_n_valid != 3'(NUM_DIGITS)) r_n_valid <= r_n_valid + 1'b1;
            end

            if (w_slot_wrap) begin
                r_slot_cnt <= '0;
                r_dig      <= r_dig + 1'b1;
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end

            // Both outputs come from the same dig/history snapshot, so they never disagree.
            r_an_n  <= (r_slot_cnt < SLOT_W'(BLANK_CYCLES)) ? 4'hF : ~(4'b0001 << r_dig);
            r_seg_n <= ({1'b0, r_dig} < r_n_valid) ? w_seg_n : SEG_BLANK;
        end
    end

    assign pif.an_n      = r_an_n;
    assign pif.seg_n     = r_seg_n;
    assign pif.led       = r_led;
    assign pif.cap_pulse = r_cap_pulse;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl with short refresh/debounce periods.
module tb_display_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cap_seen = 0;

    display_scan_ctrl_if pif();

    display_scan_ctrl #(
        .REFRESH_CYCLES (8),
        .BLANK_CYCLES   (2),
        .DEB_CYCLES     (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (pif.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n) cap_seen += int'(pif.cap_pulse);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [3:0] g);
        pif.gray_in = g;
        repeat (3) tick();
        pif.btn_raw = 1'b1;
        repeat (8) tick();
        pif.btn_raw = 1'b0;
        repeat (8) tick();
    endtask

    // Visit every digit once within a bounded window and compare its segments.
    task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [3:0] seen = '0;
        logic [6:0] exp_seg;
        int         idx;
        for (int c = 0; c < 64 && seen != 4'hF; c++) begin
            tick();
            idx = -1;
            case (pif.an_n)
                4'hE: idx = 0;
                4'hD: idx = 1;
                4'hB: idx = 2;
                4'h7: idx = 3;
                default: idx = -1;
            endcase
            if (idx >= 0 && !seen[idx]) begin
                seen[idx] = 1'b1;
                case (idx)
                    0: exp_seg = e0;
                    1: exp_seg = e1;
                    2: exp_seg = e2;
                    default: exp_seg = e3;
                endcase
                check($sformatf("%s_dig%0d", tag, idx), 32'(pif.seg_n), 32'(exp_seg));
            end
        end
        check({tag, "_all_digits_seen"}, 32'(seen), 32'hF);
    endtask

    // Returns just after the edge where the anodes go F -> E (slot counter then reads 3, dig 0).
    task automatic sync_to_digit0(output bit ok);
        logic [3:0] prev;
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            prev = pif.an_n;
            tick();
            if (prev == 4'hF && pif.an_n == 4'hE) ok = 1'b1;
        end
    endtask

    initial begin
        logic [39:0] bounce_pat;
        int          first_cap;
        int          overlap;
        logic [3:0]  exp_an;
        bit          ok;

        pif.gray_in = '0;
        pif.btn_raw = 1'b0;
        repeat (3) @(posedge clk);
        check("reset_an", 32'(pif.an_n), 32'hF);
        check("reset_seg", 32'(pif.seg_n), 32'h7F);
        check("reset_led", 32'(pif.led), 32'h0);
        #1 rst_n = 1'b1;
        tick(); check("post_rst_blank0", 32'(pif.an_n), 32'hF);
        tick(); check("post_rst_blank1", 32'(pif.an_n), 32'hF);
        tick(); check("post_rst_an_dig0", 32'(pif.an_n), 32'hE);
        check("post_rst_seg_blank", 32'(pif.seg_n), 32'h7F);

        // High runs of at most 3 cycles must never reach the debounce threshold.
        bounce_pat = 40'b1110110100111001011101001101100011100100;
        for (int i = 39; i >= 0; i--) begin
            pif.btn_raw = bounce_pat[i];
            tick();
        end
        pif.btn_raw = 1'b0;
        repeat (8) tick();
        check("bounce_no_cap", 32'(cap_seen), 32'd0);
        check("bounce_led", 32'(pif.led), 32'h0);

        pif.gray_in = 4'b1101;
        repeat (3) tick();
        pif.btn_raw = 1'b1;
        first_cap = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 10) pif.btn_raw = 1'b0;
            if (pif.cap_pulse && first_cap < 0) first_cap = k;
        end
        check("cap_latency", 32'(first_cap), 32'd6);
        check("cap_count_1", 32'(cap_seen), 32'd1);
        check("cap_led_9", 32'(pif.led), 32'h9);
        scan_check("one_cap", 7'h10, 7'h7F, 7'h7F, 7'h7F);

        capture(4'b0000);
        capture(4'b0001);
        capture(4'b0011);
        capture(4'b0010);
        capture(4'b0110);
        check("hist_cap_count", 32'(cap_seen), 32'd6);
        check("hist_led_4", 32'(pif.led), 32'h4);
        scan_check("hist", 7'h19, 7'h30, 7'h24, 7'h79);

        sync_to_digit0(ok);
        check("scan_sync", 32'(ok), 32'd1);
        overlap = 0;
        for (int t = 0; t < 64; t++) begin
            exp_an = 4'hF;
            if ((t % 8) < 6) exp_an = ~(4'b0001 << ((t / 8) % 4));
            check($sformatf("scan_an_t%0d", t), 32'(pif.an_n), 32'(exp_an));
            if ($countones(~pif.an_n) > 1) overlap++;
            tick();
        end
        check("scan_no_overlap", 32'(overlap), 32'd0);

        // Gray 0111 -> 5; capture edge lands on the dig 1 -> 2 wrap.
        pif.gray_in = 4'b0111;
        sync_to_digit0(ok);
        check("simul_sync", 32'(ok), 32'd1);
        repeat (7) tick();
        pif.btn_raw = 1'b1;
        repeat (6) tick();
        check("simul_cap_hi", 32'(pif.cap_pulse), 32'd1);
        check("simul_led_5", 32'(pif.led), 32'h5);
        tick();
        check("simul_cap_lo", 32'(pif.cap_pulse), 32'd0);
        check("simul_an_blank", 32'(pif.an_n), 32'hF);
        check("simul_seg_post", 32'(pif.seg_n), 32'h30);
        repeat (2) tick();
        check("simul_an_dig2", 32'(pif.an_n), 32'hB);
        check("simul_seg_dig2", 32'(pif.seg_n), 32'h30);
        pif.btn_raw = 1'b0;
        repeat (10) tick();
        check("simul_cap_count", 32'(cap_seen), 32'd7);
        scan_check("simul", 7'h12, 7'h19, 7'h30, 7'h24);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_an", 32'(pif.an_n), 32'hF);
        check("midrst_seg", 32'(pif.seg_n), 32'h7F);
        check("midrst_led", 32'(pif.led), 32'h0);
        check("midrst_cap", 32'(pif.cap_pulse), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        scan_check("after_rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
